mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, datapath width.
REQ-003 SHALL have parameter REG_W, default 3, register-index width.
REQ-004 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ex_valid, ex_mem_read, ex_mem_write, ex_reg_write  input  1 each  EX/MEM qualifier and controls.
REQ-007 SHALL have ports ex_alu_result, ex_store_data  input  DATA_W  effective address or ALU value; store value.
REQ-008 SHALL have port ex_rd  input  REG_W  destination register.
REQ-009 SHALL have ports stall, flush  input  1  hazard-unit hold and kill.
REQ-010 SHALL have ports dm_address  output  ADDR_W, dm_we  output  1, dm_data  output  DATA_W  data-memory drive.
REQ-011 SHALL have port dm_q  input  DATA_W  data-memory asynchronous read data.
REQ-012 SHALL have ports wb_valid, wb_reg_write  output  1, wb_rd  output  REG_W, wb_data  output  DATA_W  MEM/WB register.
REQ-013 SHALL have port fwd_data  output  DATA_W  combinational stage result for EX forwarding.

Function
REQ-014 SHALL drive dm_address = ex_alu_result[ADDR_W-1:0]; upper bits ignored (address wraps modulo 2^ADDR_W).
REQ-015 SHALL drive dm_data = ex_store_data combinationally.
REQ-016 SHALL assert dm_we only when ex_valid & ex_mem_write & ~stall & ~flush (and target is RAM, see REQ-027).
REQ-017 SHALL form result = ex_mem_read ? dm_q : ex_alu_result; fwd_data = result.
REQ-018 SHALL, on clock edge with flush=1, clear wb_valid and wb_reg_write; flush overrides stall.
REQ-019 SHALL, with stall=1 and flush=0, hold all wb_* registers unchanged.
REQ-020 SHALL otherwise load wb_valid<=ex_valid, wb_reg_write<=ex_valid&ex_reg_write, wb_rd<=ex_rd, wb_data<=result; latency one cycle.
REQ-021 SHALL treat ex_mem_read and ex_mem_write both set as a store (write performed, wb_data = dm_q pre-write value).
REQ-022 SHALL, for back-to-back store then load to same address, return the stored value (memory write at edge N visible combinationally in cycle N+1).

Reset
REQ-023 SHALL, while rst_n=0, force wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0 asynchronously.
REQ-024 SHALL suppress dm_we while rst_n=0; an in-flight store during reset is dropped.
REQ-025 SHALL resume normal capture on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL compile a memory-mapped I/O port only when macro MEM_STAGE_MMIO_EN is defined, adding ports io_in input DATA_W and io_out output DATA_W.
REQ-027 With MEM_STAGE_MMIO_EN: address all-ones (8'hFF) SHALL be I/O; stores there load io_out register (reset 0) and keep dm_we=0; loads return io_in.
REQ-028 Without MEM_STAGE_MMIO_EN: address 8'hFF SHALL be ordinary RAM and no io_* ports exist.

Structure
REQ-029 SHALL take ADDR_W/DATA_W/REG_W defaults and MMIO address constant from shared package cpu_pkg.
REQ-030 SHALL place MEM/WB register bank in sub-module mem_wb_reg (valid/stall/flush handling); mux and memory drive stay in mem_stage.

Verification
REQ-031 Store: ex_valid=1, mem_write=1, alu=16'h0012, store=16'hBEEF -> dm_we=1, dm_address=8'h12; next-cycle load from 8'h12 -> wb_data=16'hBEEF.
REQ-032 Stall: store to 8'h20 with stall=1 -> dm_we=0, wb_* unchanged; release stall -> write occurs, wb_valid=1.
REQ-033 Flush+stall same cycle: valid load in -> wb_valid=0, wb_reg_write=0 after edge.
REQ-034 Wrap: alu=16'h0105, load -> dm_address=8'h05, wb_data=ram[5].
REQ-035 Reset mid-operation: rst_n low during store -> dm_we=0, all wb_* read 0 immediately.
REQ-036 MMIO (macro on): store 16'h00A5 to 8'hFF -> io_out=16'h00A5, dm_we=0; load 8'hFF with io_in=16'h1234 -> wb_data=16'h1234.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg : shared constants for the CPU pipeline's memory stage.
//   ADDR_W_DEF : data-memory word-address width
//   DATA_W_DEF : datapath width
//   REG_W_DEF  : register-index width
//   MMIO_ADDR  : word address decoded as the memory-mapped I/O port
//                (only meaningful when MEM_STAGE_MMIO_EN is defined)
// -----------------------------------------------------------------------------
package cpu_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;

  // All-ones word address: the top RAM word is given up to I/O.
  localparam logic [ADDR_W_DEF-1:0] MMIO_ADDR = '1;
endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if : bundle of the EX/MEM inputs, hazard controls, data-memory
// drive and MEM/WB outputs of the memory stage.
//   master : pipeline/memory side (drives ex_*, stall, flush, dm_q)
//   slave  : mem_stage side (drives dm_*, wb_*, fwd_data)
// -----------------------------------------------------------------------------
interface mem_stage_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
);
  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] dm_address;
  logic              dm_we;
  logic [DATA_W-1:0] dm_data;
  logic [DATA_W-1:0] dm_q;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_alu_result, ex_store_data, ex_rd, stall, flush, dm_q,
    input  dm_address, dm_we, dm_data,
           wb_valid, wb_reg_write, wb_rd, wb_data, fwd_data
  );

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_alu_result, ex_store_data, ex_rd, stall, flush, dm_q,
    output dm_address, dm_we, dm_data,
           wb_valid, wb_reg_write, wb_rd, wb_data, fwd_data
  );
endinterface

// File: rtl/mem_stage_wb.sv
// -----------------------------------------------------------------------------
// mem_wb_reg : MEM/WB pipeline register bank.
//   i_clock, i_rst_n     : clock, async active-low reset (clears everything)
//   i_stall, i_flush     : hold / kill; flush wins over stall
//   i_valid, i_reg_write : qualifier and write-enable from the MEM stage
//   i_rd, i_data         : destination register and stage result
//   o_*                  : registered copies toward write-back
// -----------------------------------------------------------------------------
module mem_wb_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              i_clock,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic              i_reg_write,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_reg_write,
  output logic [REG_W-1:0]  o_rd,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic              r_reg_write;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
    end else if (i_flush) begin
      // Killing the qualifiers is enough; rd/data are don't-care when invalid.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!i_stall) begin
      r_valid     <= i_valid;
      r_reg_write <= i_valid & i_reg_write;
      r_rd        <= i_rd;
      r_data      <= i_data;
    end
  end

  assign o_valid     = r_valid;
  assign o_reg_write = r_reg_write;
  assign o_rd        = r_rd;
  assign o_data      = r_data;
endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : pipeline memory stage. Drives the data memory from the EX/MEM
// values, selects load data or ALU result, forwards it combinationally and
// registers it into MEM/WB (mem_wb_reg).
//   clock, rst_n : clock, async active-low reset
//   bus          : mem_stage_if.slave (ex_*, stall, flush, dm_*, wb_*, fwd_data)
//   io_in/io_out : memory-mapped I/O port, present only with MEM_STAGE_MMIO_EN
// Build option: define MEM_STAGE_MMIO_EN to decode word address MMIO_ADDR as
// I/O instead of RAM.
// -----------------------------------------------------------------------------
module mem_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  mem_stage_if.slave        bus
`ifdef MEM_STAGE_MMIO_EN
  ,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
`endif
);
  logic [ADDR_W-1:0] w_addr;
  logic              w_store_go;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_result;

  // Upper address bits are dropped: addresses wrap modulo 2^ADDR_W.
  assign w_addr = bus.ex_alu_result[ADDR_W-1:0];

  // rst_n is folded in so a store in flight while reset is low is dropped.
  assign w_store_go = rst_n & bus.ex_valid & bus.ex_mem_write & ~bus.stall & ~bus.flush;

`ifdef MEM_STAGE_MMIO_EN
  logic              w_is_io;
  logic [DATA_W-1:0] r_io_out;

  assign w_is_io   = (w_addr == ADDR_W'(MMIO_ADDR));
  assign w_rd_data = w_is_io ? io_in : bus.dm_q;
  assign bus.dm_we = w_store_go & ~w_is_io;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_io_out <= '0;
    end else if (w_store_go && w_is_io) begin
      r_io_out <= bus.ex_store_data;
    end
  end

  assign io_out = r_io_out;
`else
  assign w_rd_data = bus.dm_q;
  assign bus.dm_we = w_store_go;
`endif

  assign bus.dm_address = w_addr;
  assign bus.dm_data    = bus.ex_store_data;

  // Read+write together behaves as a store; the load path still returns the
  // pre-write memory word because dm_q is sampled before the write edge.
  assign w_result     = bus.ex_mem_read ? w_rd_data : bus.ex_alu_result;
  assign bus.fwd_data = w_result;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .i_clock     (clock),
    .i_rst_n     (rst_n),
    .i_stall     (bus.stall),
    .i_flush     (bus.flush),
    .i_valid     (bus.ex_valid),
    .i_reg_write (bus.ex_reg_write),
    .i_rd        (bus.ex_rd),
    .i_data      (w_result),
    .o_valid     (bus.wb_valid),
    .o_reg_write (bus.wb_reg_write),
    .o_rd        (bus.wb_rd),
    .o_data      (bus.wb_data)
  );
endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage : directed self-checking bench for mem_stage with a behavioural
// async-read / sync-write data RAM. RAM word i is preloaded with 16'h1000 + i.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  logic clock;
  logic rst_n;
  logic ram_load;
  logic [15:0] ram [256];
  int tests;
  int failed;

  mem_stage_if #(.ADDR_W(8), .DATA_W(16), .REG_W(3)) bus ();

`ifdef MEM_STAGE_MMIO_EN
  logic [15:0] io_in;
  logic [15:0] io_out;
`endif

  mem_stage #(.ADDR_W(8), .DATA_W(16), .REG_W(3)) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .bus    (bus.slave)
`ifdef MEM_STAGE_MMIO_EN
    ,
    .io_in  (io_in),
    .io_out (io_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'h1000 + 16'(i);
    end else if (bus.dm_we) begin
      ram[bus.dm_address] <= bus.dm_data;
    end
  end

  assign bus.dm_q = ram[bus.dm_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic rw,
                       input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] st);
    bus.ex_valid      = v;
    bus.ex_mem_read   = rd_en;
    bus.ex_mem_write  = wr_en;
    bus.ex_reg_write  = rw;
    bus.ex_rd         = rd;
    bus.ex_alu_result = alu;
    bus.ex_store_data = st;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst_n    = 1'b1;
    ram_load = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
`ifdef MEM_STAGE_MMIO_EN
    io_in = 16'h0000;
`endif
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0030, 16'hDEAD);
    #2;
    // Reset asserted with a store presented: store dropped, wb_* cleared.
    rst_n    = 1'b0;
    ram_load = 1'b1;
    #1;
    check("rst_dm_we", bus.dm_we, 1'b0);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_wb_reg_write", bus.wb_reg_write, 1'b0);
    check("rst_wb_rd", bus.wb_rd, 3'd0);
    check("rst_wb_data", bus.wb_data, 16'h0000);
    tick();
    ram_load = 1'b0;
    check("rst_ram30_kept", ram[8'h30], 16'h1030);
    check("rst_wb_valid_edge", bus.wb_valid, 1'b0);

    // Store BEEF to 0x12, then load it back in the next cycle.
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0012, 16'hBEEF);
    #1;
    check("st_dm_we", bus.dm_we, 1'b1);
    check("st_dm_address", bus.dm_address, 8'h12);
    check("st_dm_data", bus.dm_data, 16'hBEEF);
    tick();
    check("st_wb_valid", bus.wb_valid, 1'b1);
    check("st_wb_reg_write", bus.wb_reg_write, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0012, 16'h0000);
    #1;
    check("ld_fwd", bus.fwd_data, 16'hBEEF);
    check("ld_dm_we", bus.dm_we, 1'b0);
    tick();
    check("ld_wb_data", bus.wb_data, 16'hBEEF);
    check("ld_wb_rd", bus.wb_rd, 3'd3);
    check("ld_wb_reg_write", bus.wb_reg_write, 1'b1);

    // Plain ALU op passes alu_result through.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 16'h7777, 16'h0000);
    #1;
    check("alu_fwd", bus.fwd_data, 16'h7777);
    tick();
    check("alu_wb_data", bus.wb_data, 16'h7777);
    check("alu_wb_rd", bus.wb_rd, 3'd5);

    // Stalled store to 0x20: no write, wb_* held; then release.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0020, 16'hCAFE);
    bus.stall = 1'b1;
    #1;
    check("stall_dm_we", bus.dm_we, 1'b0);
    tick();
    check("stall_wb_data", bus.wb_data, 16'h7777);
    check("stall_wb_rd", bus.wb_rd, 3'd5);
    check("stall_wb_reg_write", bus.wb_reg_write, 1'b1);
    check("stall_ram20", ram[8'h20], 16'h1020);
    bus.stall = 1'b0;
    #1;
    check("unstall_dm_we", bus.dm_we, 1'b1);
    tick();
    check("unstall_wb_valid", bus.wb_valid, 1'b1);
    check("unstall_wb_reg_write", bus.wb_reg_write, 1'b0);
    check("unstall_wb_data", bus.wb_data, 16'h0020);
    check("unstall_ram20", ram[8'h20], 16'hCAFE);

    // Flush together with stall kills a valid load.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 16'h0012, 16'h0000);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    check("flush_wb_valid", bus.wb_valid, 1'b0);
    check("flush_wb_reg_write", bus.wb_reg_write, 1'b0);
    // Flushed store must not write.
    bus.stall = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0040, 16'h4444);
    #1;
    check("flush_st_dm_we", bus.dm_we, 1'b0);
    tick();
    check("flush_ram40", ram[8'h40], 16'h1040);
    bus.flush = 1'b0;

    // Address wrap: 0x0105 reads word 0x05.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0105, 16'h0000);
    #1;
    check("wrap_dm_address", bus.dm_address, 8'h05);
    tick();
    check("wrap_wb_data", bus.wb_data, 16'h1005);

    // Read+write together: store happens, result is the old word.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 16'h0007, 16'h5555);
    #1;
    check("rw_dm_we", bus.dm_we, 1'b1);
    check("rw_fwd", bus.fwd_data, 16'h1007);
    tick();
    check("rw_wb_data", bus.wb_data, 16'h1007);
    check("rw_ram7", ram[8'h07], 16'h5555);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0007, 16'h0000);
    tick();
    check("rw_reload", bus.wb_data, 16'h5555);

    // Invalid instruction: no write, no valid, no reg write.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0060, 16'h6666);
    #1;
    check("inv_dm_we", bus.dm_we, 1'b0);
    tick();
    check("inv_wb_valid", bus.wb_valid, 1'b0);
    check("inv_wb_reg_write", bus.wb_reg_write, 1'b0);

`ifdef MEM_STAGE_MMIO_EN
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h00FF, 16'h00A5);
    #1;
    check("io_st_dm_we", bus.dm_we, 1'b0);
    tick();
    check("io_out", io_out, 16'h00A5);
    check("io_ramff", ram[8'hFF], 16'h10FF);
    io_in = 16'h1234;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'h00FF, 16'h0000);
    tick();
    check("io_ld_wb_data", bus.wb_data, 16'h1234);
`else
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h00FF, 16'h00A5);
    #1;
    check("ff_st_dm_we", bus.dm_we, 1'b1);
    tick();
    check("ff_ram", ram[8'hFF], 16'h00A5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'h00FF, 16'h0000);
    tick();
    check("ff_ld_wb_data", bus.wb_data, 16'h00A5);
`endif
    check("pre_rst_wb_valid", bus.wb_valid, 1'b1);

    // Reset asserted mid-cycle during a store.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0050, 16'h9999);
    #1;
    check("mid_dm_we_pre", bus.dm_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_dm_we", bus.dm_we, 1'b0);
    check("mid_wb_valid", bus.wb_valid, 1'b0);
    check("mid_wb_reg_write", bus.wb_reg_write, 1'b0);
    check("mid_wb_rd", bus.wb_rd, 3'd0);
    check("mid_wb_data", bus.wb_data, 16'h0000);
    tick();
    check("mid_ram50", ram[8'h50], 16'h1050);

    // First edge after reset release captures normally.
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 16'h0042, 16'h0000);
    tick();
    check("post_wb_valid", bus.wb_valid, 1'b1);
    check("post_wb_data", bus.wb_data, 16'h0042);
    check("post_wb_rd", bus.wb_rd, 3'd7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
